nrs_seq_controller: RTL

NRS_SEQ_CONTROLLER -- requirements
Module: nrs_seq_controller

---
 rtl/nrs_pkg.sv | 23 ++
 rtl/nrs_shift_counter.sv | 40 ++++
 rtl/nrs_seq_controller.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/nrs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nrs_pkg
// Description : Shared NRS sequencing types and constants.
// Revision    : 1.0 - initial release
// ============================================================================
package nrs_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_FIRE_CINIT = 3'd1,
        ST_SEED       = 3'd2,
        ST_SHIFT      = 3'd3,
        ST_EVALUATE   = 3'd4,
        ST_WAIT_ACK   = 3'd5
    } nrs_state_t;

    localparam int c_nc_default = 1600;
    // The final 30 discarded Gold bits are never shifted through the LFSR.
    localparam int c_nc_skip    = 30;

endpackage
`default_nettype wire

// File: rtl/nrs_shift_counter.sv
`default_nettype none
// ============================================================================
// Module      : nrs_shift_counter
// Description : Per-port shift/evaluate cycle counter with saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module nrs_shift_counter #(
    parameter int SHIFT_LEN = 1570,
    parameter int EVAL_BITS = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic shift_done,
    output logic eval_done
);

    localparam int c_cnt_w = $clog2(SHIFT_LEN + EVAL_BITS);
    localparam logic [c_cnt_w-1:0] c_shift_last = c_cnt_w'(SHIFT_LEN - 1);
    localparam logic [c_cnt_w-1:0] c_eval_last  = c_cnt_w'(SHIFT_LEN + EVAL_BITS - 1);

    logic [c_cnt_w-1:0] r_cnt;

    // Holds at the last evaluate count so it can never wrap inside a port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (enable && (r_cnt != c_eval_last)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign shift_done = (r_cnt == c_shift_last);
    assign eval_done  = (r_cnt == c_eval_last);

endmodule
`default_nettype wire

// File: rtl/nrs_seq_controller.sv
`default_nettype none
// ============================================================================
// Module      : nrs_seq_controller
// Description : Frame/run/port sequencer driving the NRS Gold-sequence LFSR.
// Revision    : 1.0 - initial release
// ============================================================================
module nrs_seq_controller
    import nrs_pkg::*;
#(
    parameter int WIDTH_REG      = 16,
    parameter int NC             = c_nc_default,
    parameter int EVAL_BITS      = 4,
    parameter int NUM_PORTS      = 2,
    parameter int RUNS_PER_FRAME = 10,
    localparam int c_port_w = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
    localparam int c_run_w  = (RUNS_PER_FRAME > 1) ? $clog2(RUNS_PER_FRAME) : 1,
    localparam int c_addr_w = (WIDTH_REG > 1) ? $clog2(WIDTH_REG) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                new_frame,
    input  logic                frame_abort,
    input  logic                cinit_valid,
    input  logic                est_ack,
    output logic                init,
    output logic                shift_x,
    output logic                out,
    output logic                wr_en,
    output logic                cinit_run,
    output logic [c_port_w-1:0] port_sel,
    output logic [c_run_w-1:0]  run_idx,
    output logic [c_addr_w-1:0] wr_addr,
    output logic                NRS_gen_ready,
    output logic                busy
);

    localparam int c_shift_len = NC - c_nc_skip;

    if (NUM_PORTS * EVAL_BITS > WIDTH_REG) begin : g_cfg_bank_overflow
        $error("nrs_seq_controller: NUM_PORTS*EVAL_BITS exceeds WIDTH_REG");
    end
    if ((NUM_PORTS < 1) || (NUM_PORTS > 2)) begin : g_cfg_port_range
        $error("nrs_seq_controller: NUM_PORTS must be 1 or 2");
    end
    if (NC <= c_nc_skip) begin : g_cfg_nc_range
        $error("nrs_seq_controller: NC too small");
    end

    nrs_state_t r_state;
    nrs_state_t w_next_state;
    logic       r_cinit_fired;
    logic       w_shift_done;
    logic       w_eval_done;
    logic       w_last_port;
    logic       w_last_run;
    logic       w_run_end;
    logic       w_ack_go;
    logic       w_cnt_clear;
    logic       w_cnt_enable;

    assign w_last_port  = (port_sel == c_port_w'(NUM_PORTS - 1));
    assign w_last_run   = (run_idx == c_run_w'(RUNS_PER_FRAME - 1));
    assign w_run_end    = (r_state == ST_EVALUATE) && w_eval_done && w_last_port;
    assign w_ack_go     = (r_state == ST_WAIT_ACK) && (!NRS_gen_ready || est_ack);
    assign w_cnt_clear  = (r_state == ST_SEED) || frame_abort;
    assign w_cnt_enable = (r_state == ST_SHIFT) || (r_state == ST_EVALUATE);

    nrs_shift_counter #(
        .SHIFT_LEN (c_shift_len),
        .EVAL_BITS (EVAL_BITS)
    ) u_shift_counter (
        .clk        (clk),
        .rst        (rst),
        .clear      (w_cnt_clear),
        .enable     (w_cnt_enable),
        .shift_done (w_shift_done),
        .eval_done  (w_eval_done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        init         = 1'b0;
        shift_x      = 1'b0;
        out          = 1'b0;
        wr_en        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (new_frame) w_next_state = ST_FIRE_CINIT;
            end
            ST_FIRE_CINIT: begin
                if (cinit_valid) w_next_state = ST_SEED;
            end
            ST_SEED: begin
                init         = 1'b1;
                w_next_state = ST_SHIFT;
            end
            ST_SHIFT: begin
                shift_x = 1'b1;
                if (w_shift_done) w_next_state = ST_EVALUATE;
            end
            ST_EVALUATE: begin
                shift_x = 1'b1;
                out     = 1'b1;
                wr_en   = 1'b1;
                if (w_eval_done) begin
                    if (!w_last_port)    w_next_state = ST_FIRE_CINIT;
                    else if (w_last_run) w_next_state = ST_IDLE;
                    else                 w_next_state = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                if (w_ack_go) w_next_state = ST_FIRE_CINIT;
            end
            default: w_next_state = ST_IDLE;
        endcase
        if (frame_abort) w_next_state = ST_IDLE;
    end

    // The start pulse is only raised on the first FIRE_CINIT cycle of a port.
    assign cinit_run = (r_state == ST_FIRE_CINIT) && !r_cinit_fired;
    assign busy      = (r_state != ST_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cinit_fired <= 1'b0;
            port_sel      <= '0;
            run_idx       <= '0;
            wr_addr       <= '0;
            NRS_gen_ready <= 1'b0;
        end else begin
            r_cinit_fired <= (r_state == ST_FIRE_CINIT);
            if (frame_abort) begin
                port_sel      <= '0;
                run_idx       <= '0;
                wr_addr       <= '0;
                NRS_gen_ready <= 1'b0;
            end else begin
                if ((r_state == ST_IDLE) && new_frame) begin
                    port_sel <= '0;
                    run_idx  <= '0;
                    wr_addr  <= '0;
                end
                if (r_state == ST_EVALUATE) begin
                    wr_addr <= wr_addr + 1'b1;
                    if (w_eval_done && !w_last_port) port_sel <= port_sel + 1'b1;
                end
                if (w_ack_go) begin
                    run_idx  <= run_idx + 1'b1;
                    port_sel <= '0;
                    wr_addr  <= '0;
                end
                // A completing run wins over an acknowledge in the same cycle.
                if (w_run_end)    NRS_gen_ready <= 1'b1;
                else if (est_ack) NRS_gen_ready <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
